// File: rtl/pwr_sq_pkg.sv
// Shared definitions for the LH154Q LCD power sequencers (power-up and power-down):
// state encodings, the 27 MHz millisecond prescale and the panel's default dwell times.
package pwr_sq_pkg;

  localparam int unsigned MS_CNT_W = 9;
  localparam int unsigned MS_MAX   = 511;

  localparam int unsigned TICKS_PER_MS_27M = 27000;

  localparam int unsigned T_HS_MS_LH154Q  = 2;
  localparam int unsigned T_RST_MS_LH154Q = 10;
  localparam int unsigned T_3V0_MS_LH154Q = 20;
  localparam int unsigned T_1V8_MS_LH154Q = 5;

  // Encodings are ordered so that "at or past a step" is a simple magnitude compare
  localparam logic [2:0] ST_ON      = 3'd0;
  localparam logic [2:0] ST_HS_STOP = 3'd1;
  localparam logic [2:0] ST_RST_DW  = 3'd2;
  localparam logic [2:0] ST_V3V0_DW = 3'd3;
  localparam logic [2:0] ST_V1V8_DW = 3'd4;
  localparam logic [2:0] ST_OFF     = 3'd5;

  // True in the last cycle of an n_ms dwell; a zero-length dwell lasts one cycle
  function automatic logic dwell_done(input logic [MS_CNT_W-1:0] ms_cnt,
                                      input logic                cyc_zero,
                                      input logic [MS_CNT_W-1:0] n_ms);
    return (n_ms == '0) || (cyc_zero && (ms_cnt == n_ms - MS_CNT_W'(1)));
  endfunction

endpackage

// File: rtl/pwr_ms_timer.sv
// Millisecond dwell timer: a cycle prescaler feeding a saturating ms counter.
// cyc_zero flags the final cycle of the current millisecond (no cycles left in it).
module pwr_ms_timer #(
  parameter int unsigned TICKS_PER_MS = 27000,
  parameter int unsigned MS_W         = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  output logic [MS_W-1:0] ms_cnt,
  output logic            cyc_zero
);

  localparam int unsigned PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;

  assign cyc_zero = (pre_q == PRE_W'(TICKS_PER_MS - 1));
  assign ms_cnt   = ms_cnt_q;

  always_comb begin
    pre_d    = pre_q;
    ms_cnt_d = ms_cnt_q;
    if (clr) begin
      pre_d    = '0;
      ms_cnt_d = '0;
    end else if (cyc_zero) begin
      pre_d = '0;
      if (ms_cnt_q != '1) ms_cnt_d = ms_cnt_q + MS_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      ms_cnt_q <= '0;
    end else begin
      pre_q    <= pre_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

endmodule

// File: rtl/pwr_dn_sq_ctrl.sv
// LCD power-down sequencer: stops HS video, asserts LCD reset, drops 3V0, then 1V8.
// Outputs are active-high keep masks ANDed with the power-up sequencer's pad drives.
module pwr_dn_sq_ctrl
  import pwr_sq_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = TICKS_PER_MS_27M,
  parameter int unsigned T_HS_MS      = T_HS_MS_LH154Q,
  parameter int unsigned T_RST_MS     = T_RST_MS_LH154Q,
  parameter int unsigned T_3V0_MS     = T_3V0_MS_LH154Q,
  parameter int unsigned T_1V8_MS     = T_1V8_MS_LH154Q
) (
  input  logic clk,
  input  logic reset,
  input  logic pwrdn_req,
  input  logic fault_req,
  output logic hs_stop,
  output logic rst_keep,
  output logic v3v0_keep,
  output logic v1v8_keep,
  output logic busy,
  output logic pwrdn_done
);

  if (T_HS_MS > MS_MAX || T_RST_MS > MS_MAX || T_3V0_MS > MS_MAX || T_1V8_MS > MS_MAX)
  begin : g_dwell_range
    $error("pwr_dn_sq_ctrl: dwell times must fit the 9-bit ms counter (<= 511)");
  end

  if (TICKS_PER_MS < 1) begin : g_tick_range
    $error("pwr_dn_sq_ctrl: TICKS_PER_MS must be at least 1");
  end

  localparam logic [MS_CNT_W-1:0] HS_N  = MS_CNT_W'(T_HS_MS);
  localparam logic [MS_CNT_W-1:0] RST_N = MS_CNT_W'(T_RST_MS);
  localparam logic [MS_CNT_W-1:0] V3_N  = MS_CNT_W'(T_3V0_MS);
  localparam logic [MS_CNT_W-1:0] V18_N = MS_CNT_W'(T_1V8_MS);

  logic [2:0]          state_q, state_d;
  logic                hs_stop_q, hs_stop_d;
  logic                rst_keep_q, rst_keep_d;
  logic                v3v0_keep_q, v3v0_keep_d;
  logic                v1v8_keep_q, v1v8_keep_d;
  logic                busy_q, busy_d;
  logic                pwrdn_done_q, pwrdn_done_d;
  logic                tmr_clr;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                cyc_zero;

  pwr_ms_timer #(
    .TICKS_PER_MS(TICKS_PER_MS),
    .MS_W        (MS_CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .ms_cnt  (ms_cnt),
    .cyc_zero(cyc_zero)
  );

  // Outputs are decoded from the next state so they change on the entry edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ON: begin
        if (fault_req)      state_d = ST_RST_DW;
        else if (pwrdn_req) state_d = ST_HS_STOP;
      end
      ST_HS_STOP: begin
        if (fault_req || dwell_done(ms_cnt, cyc_zero, HS_N)) state_d = ST_RST_DW;
      end
      ST_RST_DW:  if (dwell_done(ms_cnt, cyc_zero, RST_N)) state_d = ST_V3V0_DW;
      ST_V3V0_DW: if (dwell_done(ms_cnt, cyc_zero, V3_N))  state_d = ST_V1V8_DW;
      ST_V1V8_DW: if (dwell_done(ms_cnt, cyc_zero, V18_N)) state_d = ST_OFF;
      ST_OFF:     state_d = ST_OFF;
      default:    state_d = ST_OFF;
    endcase

    tmr_clr      = (state_d != state_q);
    hs_stop_d    = hs_stop_q | (state_d != ST_ON);
    rst_keep_d   = rst_keep_q & (state_d < ST_RST_DW);
    v3v0_keep_d  = v3v0_keep_q & (state_d < ST_V3V0_DW);
    v1v8_keep_d  = v1v8_keep_q & (state_d < ST_V1V8_DW);
    busy_d       = (state_d != ST_ON) && (state_d != ST_OFF);
    pwrdn_done_d = pwrdn_done_q | (state_d == ST_OFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ON;
      hs_stop_q    <= 1'b0;
      rst_keep_q   <= 1'b1;
      v3v0_keep_q  <= 1'b1;
      v1v8_keep_q  <= 1'b1;
      busy_q       <= 1'b0;
      pwrdn_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_stop_q    <= hs_stop_d;
      rst_keep_q   <= rst_keep_d;
      v3v0_keep_q  <= v3v0_keep_d;
      v1v8_keep_q  <= v1v8_keep_d;
      busy_q       <= busy_d;
      pwrdn_done_q <= pwrdn_done_d;
    end
  end

  assign hs_stop    = hs_stop_q;
  assign rst_keep   = rst_keep_q;
  assign v3v0_keep  = v3v0_keep_q;
  assign v1v8_keep  = v1v8_keep_q;
  assign busy       = busy_q;
  assign pwrdn_done = pwrdn_done_q;

endmodule

// File: tb/tb_pwr_dn_sq_ctrl.sv
// Bench for pwr_dn_sq_ctrl: directed and random request schedules checked cycle by cycle
// against step times derived arithmetically from the request schedule.
module tb_pwr_dn_sq_ctrl;

  localparam int TPM   = 4;
  localparam int D_HS  = 2;
  localparam int D_RST = 3;
  localparam int D_3V0 = 4;
  localparam int D_1V8 = 1;
  localparam int H     = 64;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pwrdn_req = 1'b0;
  logic fault_req = 1'b0;
  logic hs_stop, rst_keep, v3v0_keep, v1v8_keep, busy, pwrdn_done;

  int n_checks = 0;
  int n_fail = 0;

  bit p_req[H];
  bit f_req[H];
  int t_hs, t_rst, t_3v0, t_1v8, t_done;

  pwr_dn_sq_ctrl #(
    .TICKS_PER_MS(TPM),
    .T_HS_MS     (D_HS),
    .T_RST_MS    (D_RST),
    .T_3V0_MS    (D_3V0),
    .T_1V8_MS    (D_1V8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwrdn_req (pwrdn_req),
    .fault_req (fault_req),
    .hs_stop   (hs_stop),
    .rst_keep  (rst_keep),
    .v3v0_keep (v3v0_keep),
    .v1v8_keep (v1v8_keep),
    .busy      (busy),
    .pwrdn_done(pwrdn_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic int dwell_cycles(input int n_ms);
    return (n_ms == 0) ? 1 : n_ms * TPM;
  endfunction

  // Step times in run-relative cycles, from the first request and any fault seen while draining HS
  task automatic compute_times();
    int r;
    r = -1;
    for (int c = 0; c < H; c++) begin
      if (r < 0 && (p_req[c] || f_req[c])) r = c;
    end
    if (r < 0) begin
      t_hs = NEVER; t_rst = NEVER; t_3v0 = NEVER; t_1v8 = NEVER; t_done = NEVER;
      return;
    end
    t_hs = r + 1;
    if (f_req[r]) begin
      t_rst = r + 1;
    end else begin
      t_rst = t_hs + dwell_cycles(D_HS);
      for (int c = t_hs; c < t_hs + dwell_cycles(D_HS) && c < H; c++) begin
        if (f_req[c] && t_rst == t_hs + dwell_cycles(D_HS)) t_rst = c + 1;
      end
    end
    t_3v0  = t_rst + dwell_cycles(D_RST);
    t_1v8  = t_3v0 + dwell_cycles(D_3V0);
    t_done = t_1v8 + dwell_cycles(D_1V8);
  endtask

  task automatic check_cycle(input int c);
    checkOutput($sformatf("hs_stop@%0d", c),    hs_stop,    c >= t_hs);
    checkOutput($sformatf("rst_keep@%0d", c),   rst_keep,   c < t_rst);
    checkOutput($sformatf("v3v0_keep@%0d", c),  v3v0_keep,  c < t_3v0);
    checkOutput($sformatf("v1v8_keep@%0d", c),  v1v8_keep,  c < t_1v8);
    checkOutput($sformatf("busy@%0d", c),       busy,       c >= t_hs && c < t_done);
    checkOutput($sformatf("pwrdn_done@%0d", c), pwrdn_done, c >= t_done);
  endtask

  task automatic check_reset_values(input string where);
    checkOutput({where, ":hs_stop"},    hs_stop,    1'b0);
    checkOutput({where, ":rst_keep"},   rst_keep,   1'b1);
    checkOutput({where, ":v3v0_keep"},  v3v0_keep,  1'b1);
    checkOutput({where, ":v1v8_keep"},  v1v8_keep,  1'b1);
    checkOutput({where, ":busy"},       busy,       1'b0);
    checkOutput({where, ":pwrdn_done"}, pwrdn_done, 1'b0);
  endtask

  task automatic clear_schedule();
    for (int c = 0; c < H; c++) begin
      p_req[c] = 1'b0;
      f_req[c] = 1'b0;
    end
  endtask

  // Leaves the bench 1 time unit into run cycle 0 with reset released
  task automatic start_run();
    reset = 1'b1;
    pwrdn_req = 1'b0;
    fault_req = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int n_cycles);
    compute_times();
    for (int c = 0; c < n_cycles; c++) begin
      pwrdn_req = p_req[c];
      fault_req = f_req[c];
      @(negedge clk);
      check_cycle(c);
      @(posedge clk);
      #1;
    end
    pwrdn_req = 1'b0;
    fault_req = 1'b0;
  endtask

  initial begin
    $display("[TB] power-down sequencer bench starting");

    // Orderly sequence
    clear_schedule();
    p_req[0] = 1'b1;
    start_run();
    applyStimulus(50);

    // Fault straight from ON
    clear_schedule();
    f_req[0] = 1'b1;
    start_run();
    applyStimulus(50);

    // Fault while draining HS
    clear_schedule();
    p_req[0] = 1'b1;
    f_req[4] = 1'b1;
    start_run();
    applyStimulus(50);

    // Both requests together
    clear_schedule();
    p_req[0] = 1'b1;
    f_req[0] = 1'b1;
    start_run();
    applyStimulus(50);

    // Late and repeated requests are ignored
    clear_schedule();
    p_req[0]  = 1'b1;
    p_req[15] = 1'b1;
    f_req[25] = 1'b1;
    p_req[45] = 1'b1;
    p_req[50] = 1'b1;
    f_req[52] = 1'b1;
    start_run();
    applyStimulus(H);

    // Async reset in the 3V0 dwell, then a fresh request after release
    clear_schedule();
    p_req[0] = 1'b1;
    start_run();
    applyStimulus(22);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset_edge");
    for (int c = 22; c < 30; c++) begin
      @(negedge clk);
      check_reset_values($sformatf("held_reset@%0d", c));
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    clear_schedule();
    p_req[2] = 1'b1;
    applyStimulus(50);

    // Random request schedules
    for (int run = 0; run < 24; run++) begin
      clear_schedule();
      for (int c = 0; c < H; c++) begin
        p_req[c] = ($urandom_range(0, 9) == 0);
        f_req[c] = ($urandom_range(0, 24) == 0);
      end
      start_run();
      applyStimulus(H);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
